// File: rtl/fetch_pkg.sv
// Shared widths, reset PC and the buffered fetch-entry type for the fetch stage.
package fetch_pkg;

   localparam int unsigned ADDR_W      = 8;
   localparam int unsigned DATA_W      = 32;
   localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;
   localparam int unsigned INSTR_BYTES = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO holding {pc, instr} pairs between fetch and decode.
// Flush wins over push and pop; push when full is accepted only with a pop.
module fetch_skid_fifo
   import fetch_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t wdata_i,
   output fetch_entry_t rdata_o,
   output logic [1:0]   count_o
);

   fetch_entry_t mem_q [2];
   logic         rd_ptr_q, rd_ptr_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         do_push, do_pop;

   assign do_pop  = pop_i & (count_q != 2'd0);
   assign do_push = push_i & ((count_q != 2'd2) | do_pop);

   // Pointer and occupancy next-state; flush empties the buffer outright.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (do_push) wr_ptr_d = ~wr_ptr_q;
         if (do_pop)  rd_ptr_d = ~rd_ptr_q;
         unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // State registers; storage is cleared on reset so the head reads zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, addresses the ROM, buffers up to two fetched words
// for decode and handles redirects that flush the buffer.
module instr_fetch
   import fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_instr,
   output logic [ADDR_W-1:0] fetch_pc,
   input  logic              fetch_ready,
   output logic              misalign
);

   localparam logic [ADDR_W-1:0] PcStep = ADDR_W'(INSTR_BYTES);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              misalign_q, misalign_d;
   logic [1:0]        count;
   logic              pop, capture;
   fetch_entry_t      push_entry, head_entry;

   assign fetch_valid = (count != 2'd0);
   assign pop         = fetch_valid & fetch_ready;
   // A full buffer may still take a word when decode frees a slot this cycle.
   assign capture     = enable & ~redirect_valid & ((count != 2'd2) | pop);

   assign push_entry.pc    = pc_q;
   assign push_entry.instr = rom_data;

   // Next PC: redirect (word-aligned) beats sequential advance; wraps modulo 2^ADDR_W.
   always_comb begin
      pc_d       = pc_q;
      misalign_d = 1'b0;
      if (redirect_valid) begin
         pc_d       = {redirect_pc[ADDR_W-1:2], 2'b00};
         misalign_d = |redirect_pc[1:0];
      end else if (capture) begin
         pc_d = pc_q + PcStep;
      end
   end

   // PC and misalign pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

   fetch_skid_fifo u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .push_i  (capture),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .wdata_i (push_entry),
      .rdata_o (head_entry),
      .count_o (count)
   );

   assign rom_addr    = pc_q;
   assign fetch_pc    = head_entry.pc;
   assign fetch_instr = head_entry.instr;
   assign misalign    = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a scoreboard of expected deliveries.
module tb_instr_fetch;
   import fetch_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              enable;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              fetch_valid;
   logic [DATA_W-1:0] fetch_instr;
   logic [ADDR_W-1:0] fetch_pc;
   logic              fetch_ready;
   logic              misalign;

   int n_checks = 0;
   int n_err    = 0;
   int cyc;
   logic [ADDR_W-1:0] exp_q [$];

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_valid    (fetch_valid),
      .fetch_instr    (fetch_instr),
      .fetch_pc       (fetch_pc),
      .fetch_ready    (fetch_ready),
      .misalign       (misalign)
   );

   function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
      case (a)
         8'h00:   rom_word = 32'h00000000;
         8'h04:   rom_word = 32'h00450693;
         8'h08:   rom_word = 32'h00100713;
         8'h18:   rom_word = 32'h00068613;
         8'h1C:   rom_word = 32'h00070793;
         default: rom_word = {16'hA55A, 8'h00, a};
      endcase
   endfunction

   assign rom_data = rom_word(rom_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   // One clock: compare any delivery at the negedge, then return #1 after the posedge.
   task automatic tick();
      logic [ADDR_W-1:0] e;
      @(negedge clk);
      if (fetch_valid && fetch_ready) begin
         n_checks++;
         assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL unexpected_pop: observed pc %h required no delivery", fetch_pc);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pop_pc", 32'(fetch_pc), 32'(e));
            check("pop_instr", fetch_instr, rom_word(e));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(output int cycles);
      cycles = 0;
      while (exp_q.size() != 0 && cycles < 20) begin
         tick();
         cycles++;
      end
      check("drain_left", 32'(exp_q.size()), 0);
      exp_q.delete();
   endtask

   task automatic redirect(input logic [ADDR_W-1:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      tick();
      redirect_valid = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      enable         = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      fetch_ready    = 1'b0;
      repeat (2) tick();
      check("rst_valid", 32'(fetch_valid), 0);
      check("rst_addr", 32'(rom_addr), 0);
      check("rst_misalign", 32'(misalign), 0);
      check("rst_pc", 32'(fetch_pc), 0);
      check("rst_instr", fetch_instr, 0);

      // Stream straight out of reset.
      rst_n       = 1'b1;
      enable      = 1'b1;
      fetch_ready = 1'b1;
      check("first_valid_low", 32'(fetch_valid), 0);
      exp_q.push_back(8'h00); exp_q.push_back(8'h04); exp_q.push_back(8'h08);
      drain(cyc);
      check("stream_cycles", 32'(cyc), 4);
      fetch_ready = 1'b0;

      // Back-pressure from PC 0.
      redirect(8'h00);
      check("bp_valid0", 32'(fetch_valid), 0);
      check("bp_addr0", 32'(rom_addr), 0);
      repeat (2) tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         check("bp_head_pc", 32'(fetch_pc), 32'h00);
         check("bp_head_instr", fetch_instr, 32'h00000000);
         check("bp_addr_frozen", 32'(rom_addr), 32'h08);
      end
      exp_q.push_back(8'h00); exp_q.push_back(8'h04); exp_q.push_back(8'h08);
      fetch_ready = 1'b1;
      drain(cyc);
      check("bp_cycles", 32'(cyc), 3);
      fetch_ready = 1'b0;

      // Redirect to 18 while full and popping: 0C delivered, 10 discarded.
      exp_q.push_back(8'h0C);
      fetch_ready = 1'b1;
      redirect(8'h18);
      check("rd_valid_low", 32'(fetch_valid), 0);
      check("rd_addr", 32'(rom_addr), 32'h18);
      check("rd_misalign_low", 32'(misalign), 0);
      check("rd_popped", 32'(exp_q.size()), 0);
      exp_q.push_back(8'h18); exp_q.push_back(8'h1C);
      drain(cyc);
      check("rd_cycles", 32'(cyc), 3);
      fetch_ready = 1'b0;

      // Misaligned redirect.
      redirect(8'h1A);
      check("mis_pulse", 32'(misalign), 1);
      check("mis_addr", 32'(rom_addr), 32'h18);
      check("mis_valid_low", 32'(fetch_valid), 0);
      tick();
      check("mis_pulse_end", 32'(misalign), 0);
      exp_q.push_back(8'h18); exp_q.push_back(8'h1C);
      fetch_ready = 1'b1;
      drain(cyc);
      fetch_ready = 1'b0;

      // PC wrap.
      redirect(8'hFC);
      check("wrap_addr", 32'(rom_addr), 32'hFC);
      exp_q.push_back(8'hFC); exp_q.push_back(8'h00); exp_q.push_back(8'h04);
      fetch_ready = 1'b1;
      drain(cyc);
      check("wrap_cycles", 32'(cyc), 4);
      fetch_ready = 1'b0;

      // enable low holds the PC; pops still drain.
      enable = 1'b0;
      redirect(8'h40);
      repeat (2) tick();
      check("en_hold_addr", 32'(rom_addr), 32'h40);
      check("en_hold_valid", 32'(fetch_valid), 0);
      enable = 1'b1;
      repeat (2) tick();
      enable = 1'b0;
      exp_q.push_back(8'h40); exp_q.push_back(8'h44);
      fetch_ready = 1'b1;
      drain(cyc);
      fetch_ready = 1'b0;
      check("en_drained", 32'(fetch_valid), 0);
      check("en_addr", 32'(rom_addr), 32'h48);

      // Asynchronous reset with a full buffer.
      enable = 1'b1;
      repeat (2) tick();
      check("mid_valid", 32'(fetch_valid), 1);
      check("mid_addr", 32'(rom_addr), 32'h50);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(fetch_valid), 0);
      check("arst_addr", 32'(rom_addr), 0);
      check("arst_pc", 32'(fetch_pc), 0);
      check("arst_instr", fetch_instr, 0);
      tick();
      rst_n = 1'b1;
      exp_q.push_back(8'h00); exp_q.push_back(8'h04);
      fetch_ready = 1'b1;
      drain(cyc);
      check("restart_cycles", 32'(cyc), 3);
      fetch_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
